// File: rtl/msg_read_sequencer.sv
// msg_read_sequencer: reads a header and LEN payload bytes from slave_device.
// Payload is streamed out through a small skid FIFO. An ack read then
// advances the slave's message counter.
module msg_read_sequencer #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        start,
  input  logic [7:0]  len,
  output logic        busy,
  output logic        done,
  output logic [15:0] hdr,
  output logic        hdr_valid,
  output logic [7:0]  byte_o,
  output logic        byte_valid,
  output logic        byte_last,
  input  logic        byte_ready,
  output logic [15:0] rd_addr,
  output logic        ram_rd_rq,
  input  logic [7:0]  slave_data
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int unsigned TL = RD_LAT - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_DRAIN, S_ACK0, S_ACK1, S_DONE
  } state_e;

  typedef enum logic [1:0] {TAG_HI, TAG_LO, TAG_PAY} tag_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      len_q, len_d;

  logic [RD_LAT-1:0] trk_v_q, trk_v_d;
  logic [RD_LAT-1:0] trk_last_q, trk_last_d;
  tag_e              trk_tag_q [RD_LAT];
  tag_e              trk_tag_d [RD_LAT];

  logic [15:0]     hdr_q, hdr_d;
  logic            hdr_valid_q, hdr_valid_d;

  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

  logic            iss_v;
  tag_e            iss_tag;
  logic            iss_last;
  logic [CW-1:0]   inflight;
  logic            credit;
  logic            push;
  logic            pop;
  logic [15:0]     pay_addr;

  // Payload reads still travelling through the slave pipeline.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      if (trk_v_q[i] && (trk_tag_q[i] == TAG_PAY)) inflight = inflight + CW'(1);
    end
    credit   = (fifo_cnt_q + inflight) < CW'(FIFO_DEPTH);
    pay_addr = {8'h00, cnt_q} + 16'd2;
  end

  // Sequencer next-state, read issue and status outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    iss_v     = 1'b0;
    iss_tag   = TAG_PAY;
    iss_last  = 1'b0;
    rd_addr   = '0;
    ram_rd_rq = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          state_d = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        iss_v   = 1'b1;
        iss_tag = TAG_HI;
        state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        rd_addr = 16'd1;
        iss_v   = 1'b1;
        iss_tag = TAG_LO;
        state_d = (len_q != 8'd0) ? S_PAYLOAD : S_DRAIN;
      end
      S_PAYLOAD: begin
        rd_addr = pay_addr;
        if (credit) begin
          ram_rd_rq = 1'b1;
          iss_v     = 1'b1;
          iss_tag   = TAG_PAY;
          iss_last  = (cnt_q == len_q - 8'd1);
          cnt_d     = cnt_q + 8'd1;
          if (iss_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rd_addr = 16'd1;
        if ((trk_v_q == '0) && (fifo_cnt_q == '0)) state_d = S_ACK0;
      end
      S_ACK0: state_d = S_ACK1;
      S_ACK1: begin
        ram_rd_rq = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tracker shift and routing of returning slave data.
  always_comb begin
    trk_v_d[0]    = iss_v;
    trk_tag_d[0]  = iss_tag;
    trk_last_d[0] = iss_last;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      trk_v_d[i]    = trk_v_q[i-1];
      trk_tag_d[i]  = trk_tag_q[i-1];
      trk_last_d[i] = trk_last_q[i-1];
    end
    hdr_d       = hdr_q;
    hdr_valid_d = 1'b0;
    push        = 1'b0;
    if (trk_v_q[TL]) begin
      unique case (trk_tag_q[TL])
        TAG_HI: hdr_d[15:8] = slave_data;
        TAG_LO: begin
          hdr_d[7:0]  = slave_data;
          hdr_valid_d = 1'b1;
        end
        default: push = 1'b1;
      endcase
    end
  end

  // FIFO pointers and fill count; push and pop may coincide at any level.
  always_comb begin
    pop        = (fifo_cnt_q != '0) && byte_ready;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CW'(1);
  end

  // FIFO output view.
  always_comb begin
    byte_valid = (fifo_cnt_q != '0);
    byte_o     = mem_q[rd_ptr_q][7:0];
    byte_last  = byte_valid & mem_q[rd_ptr_q][8];
    hdr        = hdr_q;
    hdr_valid  = hdr_valid_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      trk_v_q     <= '0;
      trk_last_q  <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) trk_tag_q[i] <= TAG_HI;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      trk_v_q     <= trk_v_d;
      trk_last_q  <= trk_last_d;
      for (int unsigned i = 0; i < RD_LAT; i++) trk_tag_q[i] <= trk_tag_d[i];
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // FIFO storage: {last, data}; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {trk_last_q[TL], slave_data};
  end

  // The credit rule keeps a push from ever landing on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
    !(push && !pop && (fifo_cnt_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_msg_read_sequencer.sv
// Bench for msg_read_sequencer with a behavioural slave_device model.
module tb_msg_read_sequencer;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        busy, done, hdr_valid, byte_valid, byte_last, ram_rd_rq;
  logic [15:0] hdr, rd_addr;
  logic [7:0]  byte_o;
  logic        byte_ready = 1'b0;
  logic [7:0]  slave_data = '0;

  int total = 0;
  int bad = 0;

  msg_read_sequencer #(.RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .len(len), .busy(busy), .done(done),
    .hdr(hdr), .hdr_valid(hdr_valid), .byte_o(byte_o), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .rd_addr(rd_addr),
    .ram_rd_rq(ram_rd_rq), .slave_data(slave_data)
  );

  always #5 clk = ~clk;

  // Slave model: address registered, then data registered (two-cycle latency).
  logic [15:0] s_addr_q = '0;
  logic        s_rq_q = 1'b0;
  logic [15:0] s_hdr = 16'h1234;

  function automatic logic [7:0] pay_at(input logic [15:0] a);
    logic [15:0] v;
    v = a * 16'd37 + 16'd11;
    return v[7:0];
  endfunction

  always @(posedge clk) begin
    s_addr_q <= rd_addr;
    s_rq_q   <= ram_rd_rq;
    if (s_addr_q == 16'd0)      slave_data <= s_hdr[15:8];
    else if (s_addr_q == 16'd1) slave_data <= s_hdr[7:0];
    else                        slave_data <= pay_at(s_addr_q);
    if (s_rq_q && (s_addr_q == 16'd0)) s_hdr <= s_hdr + 16'd1;
  end

  // Monitor, sampled on the falling edge; cleared when mon_gen changes.
  int          mon_gen = 0;
  int          seen_gen = 0;
  logic [8:0]  rx_q[$];
  logic [15:0] addr_log[$];
  logic        rq_log[$];
  int          hv_cnt, done_cnt, pay_iss;
  logic [15:0] hv_val, last_pay_addr;

  always @(negedge clk) begin
    if (mon_gen != seen_gen) begin
      seen_gen = mon_gen;
      rx_q.delete(); addr_log.delete(); rq_log.delete();
      hv_cnt = 0; done_cnt = 0; pay_iss = 0;
      hv_val = '0; last_pay_addr = '0;
    end
    if (byte_valid && byte_ready) rx_q.push_back({byte_last, byte_o});
    if (hdr_valid) begin hv_cnt++; hv_val = hdr; end
    if (done) done_cnt++;
    if (ram_rd_rq && (rd_addr != 16'd0)) begin pay_iss++; last_pay_addr = rd_addr; end
    if (busy) begin addr_log.push_back(rd_addr); rq_log.push_back(ram_rd_rq); end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_hdr"}, 32'(hdr), 32'd0);
    check({tag, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_byte_last"}, 32'(byte_last), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_rq"}, 32'(ram_rd_rq), 32'd0);
  endtask

  // One message: mode 0 ready high, mode 1 ready toggling; poke_at issues a
  // start(len=9) while busy; stall holds ready low for that many cycles.
  task automatic run_msg(input string nm, input int l, input int mode, input int poke_at,
                         input int stall, input logic [15:0] exp_hdr);
    int cyc;
    mon_gen++;
    @(posedge clk); #1;
    start = 1'b1; len = 8'(l);
    byte_ready = (stall > 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b0; len = 8'hEE;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (poke_at > 0 && cyc == poke_at) begin start = 1'b1; len = 8'd9; end
      else start = 1'b0;
      if (stall > 0 && cyc == stall) begin
        check({nm, "_stall_issued"}, 32'(pay_iss), 32'd4);
        check({nm, "_stall_rq"}, 32'(ram_rd_rq), 32'd0);
        check({nm, "_stall_valid"}, 32'(byte_valid), 32'd1);
        byte_ready = 1'b1;
      end else if (mode == 1) begin
        byte_ready = ~byte_ready;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({nm, "_done_seen"}, 32'(done_cnt), 32'd1);
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
    check({nm, "_hv_cnt"}, 32'(hv_cnt), 32'd1);
    check({nm, "_hdr"}, 32'(hv_val), 32'(exp_hdr));
    check({nm, "_nbytes"}, 32'(rx_q.size()), 32'(l));
    check({nm, "_niss"}, 32'(pay_iss), 32'(l));
    if (l > 0) check({nm, "_last_addr"}, 32'(last_pay_addr), 32'(l + 1));
    for (int i = 0; i < rx_q.size() && i < l; i++) begin
      check($sformatf("%s_byte%0d", nm, i), 32'(rx_q[i]),
            32'({(i == l - 1) ? 1'b1 : 1'b0, pay_at(16'(i + 2))}));
    end
    check({nm, "_slave_cnt"}, 32'(s_hdr), 32'(exp_hdr + 16'd1));
  endtask

  typedef struct {
    int          l;
    int          mode;
    int          poke;
    int          stall;
    logic [15:0] hdr;
  } vec_t;

  vec_t vecs[5];

  logic [15:0] exp_a[4];
  logic        exp_r[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{l: 0,   mode: 0, poke: 0, stall: 0,  hdr: 16'h1235};
    vecs[1] = '{l: 255, mode: 1, poke: 0, stall: 0,  hdr: 16'h1236};
    vecs[2] = '{l: 5,   mode: 0, poke: 3, stall: 0,  hdr: 16'h1237};
    vecs[3] = '{l: 1,   mode: 1, poke: 0, stall: 0,  hdr: 16'h1238};
    vecs[4] = '{l: 8,   mode: 0, poke: 0, stall: 20, hdr: 16'h1239};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_l = 1'b1;
    repeat (2) @(posedge clk);

    // Basic three-byte message with the exact address/request sequence.
    run_msg("len3", 3, 0, 0, 0, 16'h1234);
    check("len3_log_len", 32'(addr_log.size() >= 9), 32'd1);
    if (addr_log.size() >= 9) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("len3_addr%0d", i), 32'(addr_log[i]), 32'(i));
        check($sformatf("len3_rq%0d", i), 32'(rq_log[i]), (i >= 2) ? 32'd1 : 32'd0);
      end
      exp_a = '{16'd1, 16'd0, 16'd0, 16'd0};
      exp_r = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        check($sformatf("len3_tail_addr%0d", i),
              32'(addr_log[addr_log.size() - 4 + i]), 32'(exp_a[i]));
        check($sformatf("len3_tail_rq%0d", i),
              32'(rq_log[rq_log.size() - 4 + i]), 32'(exp_r[i]));
      end
    end

    for (int v = 0; v < 5; v++) begin
      run_msg($sformatf("vec%0d", v), vecs[v].l, vecs[v].mode, vecs[v].poke,
              vecs[v].stall, vecs[v].hdr);
    end

    // Reset during the third payload cycle abandons the message.
    mon_gen++;
    @(posedge clk); #1;
    start = 1'b1; len = 8'd8; byte_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_in_payload_rq", 32'(ram_rd_rq), 32'd1);
    rst_l = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_slave_cnt", 32'(s_hdr), 32'h123A);
    rst_l = 1'b1;
    repeat (2) @(posedge clk);
    run_msg("after_abort", 2, 0, 0, 0, 16'h123A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
